// File: rtl/serial_comparator_frame_fsm.sv
// Frame-based serial magnitude comparator: compares two operands streamed DIGIT_W bits per cycle.
// Latency: running verdict is combinational (0 cycles); final verdict registered 1 cycle after 'last'.
// Backpressure: none; every valid digit is consumed, and valid=0 cycles simply hold the state.
//
// Ports:
//   clk, rst                         clock and synchronous active-high reset
//   valid, first, last               digit qualifier and frame delimiters (first/last only count with valid)
//   a, b                             operand digits, DIGIT_W bits each
//   a_less_b, a_eq_b, a_greater_b    one-hot running result including the current digit
//   res_valid                        one-cycle pulse when the final frame result is available
//   res_less, res_eq, res_greater    registered final result, held until the next frame ends
//   len_err                          frame length error pulse
//
// Optional feature: define SERIAL_CMP_LEN_CHECK_EN to enable the FRAME_DIGITS length check;
// without it len_err is tied to 0 and no digit counter exists.
module serial_comparator_frame_fsm #(
  parameter int DIGIT_W      = 1,
  parameter int MSB_FIRST    = 1,
  parameter int SIGNED       = 0,
  parameter int FRAME_DIGITS = 8
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               valid,
  input  logic               first,
  input  logic               last,
  input  logic [DIGIT_W-1:0] a,
  input  logic [DIGIT_W-1:0] b,
  output logic               a_less_b,
  output logic               a_eq_b,
  output logic               a_greater_b,
  output logic               res_valid,
  output logic               res_less,
  output logic               res_eq,
  output logic               res_greater,
  output logic               len_err
);

  typedef enum logic [1:0] {
    ST_EQ = 2'd0,
    ST_LT = 2'd1,
    ST_GT = 2'd2
  } state_t;

  state_t state_q;
  state_t state_d;
  state_t prev_st;
  state_t next_st;
  state_t cmp;
  state_t shown;

  logic               sign_digit;
  logic [DIGIT_W-1:0] a_adj;
  logic [DIGIT_W-1:0] b_adj;
  logic               frame_end;

  assign frame_end = valid & last;

  // The sign digit is the most significant one: it opens the frame when MSB
  // first, and closes it when LSB first.
  always_comb begin
    sign_digit = 1'b0;
    if (SIGNED != 0) begin
      sign_digit = (MSB_FIRST != 0) ? first : last;
    end
  end

  // Flipping the sign bit of both digits maps two's-complement order onto
  // unsigned order, so a single unsigned compare serves both cases.
  always_comb begin
    a_adj = a;
    b_adj = b;
    if (sign_digit) begin
      a_adj[DIGIT_W-1] = ~a[DIGIT_W-1];
      b_adj[DIGIT_W-1] = ~b[DIGIT_W-1];
    end
  end

  always_comb begin
    cmp = ST_EQ;
    if (a_adj < b_adj) begin
      cmp = ST_LT;
    end else if (a_adj > b_adj) begin
      cmp = ST_GT;
    end
  end

  // Next-state and output logic.
  always_comb begin
    prev_st = (valid && first) ? ST_EQ : state_q;
    next_st = prev_st;
    if (MSB_FIRST != 0) begin
      // Most significant difference seen first decides; later digits cannot change it.
      if (prev_st == ST_EQ) begin
        next_st = cmp;
      end
    end else begin
      // Each more significant digit overrides unless it is equal.
      if (cmp != ST_EQ) begin
        next_st = cmp;
      end
    end

    state_d = state_q;
    if (valid) begin
      state_d = last ? ST_EQ : next_st;
    end

    shown       = valid ? next_st : state_q;
    a_less_b    = (shown == ST_LT);
    a_greater_b = (shown == ST_GT);
    a_eq_b      = (shown == ST_EQ);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_EQ;
      res_valid   <= 1'b0;
      res_less    <= 1'b0;
      res_eq      <= 1'b0;
      res_greater <= 1'b0;
    end else begin
      state_q   <= state_d;
      res_valid <= frame_end;
      if (frame_end) begin
        res_less    <= (next_st == ST_LT);
        res_eq      <= (next_st == ST_EQ);
        res_greater <= (next_st == ST_GT);
      end
    end
  end

`ifdef SERIAL_CMP_LEN_CHECK_EN
  localparam int CNT_W = $clog2(FRAME_DIGITS + 1);
  localparam logic [CNT_W:0] FD_EXT = (CNT_W+1)'(FRAME_DIGITS);

  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W:0]   cnt_inc;
  logic             len_err_q;

  // One spare bit so the saturated count plus this digit cannot wrap.
  always_comb begin
    cnt_inc = (first ? '0 : {1'b0, cnt_q}) + (CNT_W+1)'(1);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q     <= '0;
      len_err_q <= 1'b0;
    end else begin
      len_err_q <= 1'b0;
      if (valid) begin
        if (last) begin
          len_err_q <= (cnt_inc != FD_EXT);
          cnt_q     <= '0;
        end else begin
          // Reaching the full length without 'last' is flagged once; the
          // count then saturates so the missing delimiter is not re-flagged.
          len_err_q <= (cnt_inc == FD_EXT);
          cnt_q     <= (cnt_inc >= FD_EXT) ? FD_EXT[CNT_W-1:0] : cnt_inc[CNT_W-1:0];
        end
      end
    end
  end

  assign len_err = len_err_q;
`else
  assign len_err = 1'b0;
`endif

endmodule

// File: tb/tb_serial_comparator_frame_fsm.sv
module tb_serial_comparator_frame_fsm;

  localparam logic [2:0] R_LT = 3'b100;
  localparam logic [2:0] R_EQ = 3'b010;
  localparam logic [2:0] R_GT = 3'b001;
  localparam logic [2:0] R_0  = 3'b000;
  localparam int FD = 4;
`ifdef SERIAL_CMP_LEN_CHECK_EN
  localparam bit LE_ON = 1'b1;
`else
  localparam bit LE_ON = 1'b0;
`endif

  // Instance configurations: digit width, MSB first, signed.
  localparam int CW [4] = '{4, 1, 4, 4};
  localparam int CM [4] = '{1, 0, 1, 0};
  localparam int CS [4] = '{0, 0, 1, 1};

  logic       clk = 1'b0;
  logic       rst, valid, first, last;
  logic [3:0] a, b;
  logic [3:0] lt, eq, gt, rv, rl, re, rg, le;

  always #5 clk = ~clk;

  serial_comparator_frame_fsm #(.DIGIT_W(4), .MSB_FIRST(1), .SIGNED(0), .FRAME_DIGITS(FD)) u0 (
    .clk(clk), .rst(rst), .valid(valid), .first(first), .last(last), .a(a), .b(b),
    .a_less_b(lt[0]), .a_eq_b(eq[0]), .a_greater_b(gt[0]), .res_valid(rv[0]),
    .res_less(rl[0]), .res_eq(re[0]), .res_greater(rg[0]), .len_err(le[0]));
  serial_comparator_frame_fsm #(.DIGIT_W(1), .MSB_FIRST(0), .SIGNED(0), .FRAME_DIGITS(FD)) u1 (
    .clk(clk), .rst(rst), .valid(valid), .first(first), .last(last), .a(a[0:0]), .b(b[0:0]),
    .a_less_b(lt[1]), .a_eq_b(eq[1]), .a_greater_b(gt[1]), .res_valid(rv[1]),
    .res_less(rl[1]), .res_eq(re[1]), .res_greater(rg[1]), .len_err(le[1]));
  serial_comparator_frame_fsm #(.DIGIT_W(4), .MSB_FIRST(1), .SIGNED(1), .FRAME_DIGITS(FD)) u2 (
    .clk(clk), .rst(rst), .valid(valid), .first(first), .last(last), .a(a), .b(b),
    .a_less_b(lt[2]), .a_eq_b(eq[2]), .a_greater_b(gt[2]), .res_valid(rv[2]),
    .res_less(rl[2]), .res_eq(re[2]), .res_greater(rg[2]), .len_err(le[2]));
  serial_comparator_frame_fsm #(.DIGIT_W(4), .MSB_FIRST(0), .SIGNED(1), .FRAME_DIGITS(FD)) u3 (
    .clk(clk), .rst(rst), .valid(valid), .first(first), .last(last), .a(a), .b(b),
    .a_less_b(lt[3]), .a_eq_b(eq[3]), .a_greater_b(gt[3]), .res_valid(rv[3]),
    .res_less(rl[3]), .res_eq(re[3]), .res_greater(rg[3]), .len_err(le[3]));

  int n_checks = 0;
  int n_fail   = 0;

  task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic logic [2:0] run_of(input int k);
    return {lt[k], eq[k], gt[k]};
  endfunction

  function automatic logic [2:0] res_of(input int k);
    return {rl[k], re[k], rg[k]};
  endfunction

  // ---------------- directed vector table ----------------
  typedef struct packed {
    logic [1:0] inst;
    logic       r, v, f, l;
    logic [3:0] a, b;
    logic       ck;
    logic [2:0] run;
    logic       rv;
    logic [2:0] res;
    logic       le;
  } vec_t;

  vec_t tbl [64];
  int   ntbl = 0;

  task automatic add(input int k, input bit r, input bit v, input bit f, input bit l,
                     input logic [3:0] av, input logic [3:0] bv, input bit ck,
                     input logic [2:0] run, input bit rvv, input logic [2:0] res, input bit lev);
    tbl[ntbl] = '{inst: 2'(k), r: r, v: v, f: f, l: l, a: av, b: bv, ck: ck,
                  run: run, rv: rvv, res: res, le: lev};
    ntbl++;
  endtask

  task automatic add_rst();
    add(0, 1, 0, 0, 0, 4'h0, 4'h0, 0, R_0, 0, R_0, 0);
  endtask

  // ---------------- behavioural reference model ----------------
  logic [3:0] fa [16];
  logic [3:0] fb [16];
  int         m_n = 0;
  bit         m_rv = 0;
  bit         m_le = 0;
  logic [2:0] m_res [4];

  // Compare the integers formed by the digits of the current frame.
  function automatic logic [2:0] mcmp(input int k, input int cnt, input bit complete);
    longint va = 0, vb = 0;
    longint mask = (64'sd1 <<< CW[k]) - 1;
    for (int i = 0; i < cnt; i++) begin
      int sh = (CM[k] != 0) ? (cnt - 1 - i) * CW[k] : i * CW[k];
      va = va | ((longint'(fa[i]) & mask) <<< sh);
      vb = vb | ((longint'(fb[i]) & mask) <<< sh);
    end
    if (CS[k] != 0 && cnt > 0 && (CM[k] != 0 || complete)) begin
      int top = cnt * CW[k] - 1;
      if (((va >>> top) & 1) != 0) va = va - (64'sd1 <<< (top + 1));
      if (((vb >>> top) & 1) != 0) vb = vb - (64'sd1 <<< (top + 1));
    end
    if (va < vb) return R_LT;
    if (va > vb) return R_GT;
    return R_EQ;
  endfunction

  task automatic rcycle(input bit v, input bit f, input bit l, input logic [3:0] av, input logic [3:0] bv);
    logic [2:0] exp_run [4];
    valid = v; first = f; last = l; a = av; b = bv;
    if (v) begin
      if (f) m_n = 0;
      fa[m_n] = av;
      fb[m_n] = bv;
      m_n++;
    end
    @(negedge clk);
    for (int k = 0; k < 4; k++) begin
      exp_run[k] = mcmp(k, m_n, v && l);
      chk($sformatf("rnd_run%0d", k), 8'(run_of(k)), 8'(exp_run[k]));
      chk($sformatf("rnd_rv%0d", k), 8'(rv[k]), 8'(m_rv));
      chk($sformatf("rnd_res%0d", k), 8'(res_of(k)), 8'(m_res[k]));
      chk($sformatf("rnd_le%0d", k), 8'(le[k]), 8'(m_le));
    end
    m_rv = v && l;
    m_le = 1'b0;
    if (LE_ON && v) m_le = l ? (m_n != FD) : (m_n == FD);
    if (v && l) begin
      for (int k = 0; k < 4; k++) m_res[k] = exp_run[k];
      m_n = 0;
    end
    @(posedge clk);
    #1;
  endtask

  initial begin
    logic [15:0] ta, tb2, el, ee;
    int len;
    bit f, l;
    logic [3:0] av, bv;

    rst = 1'b1; valid = 1'b0; first = 1'b0; last = 1'b0; a = 4'h0; b = 4'h0;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    for (int k = 0; k < 4; k++) begin
      chk($sformatf("reset_run%0d", k), 8'(run_of(k)), 8'(R_EQ));
      chk($sformatf("reset_rv%0d", k), 8'(rv[k]), 8'd0);
      chk($sformatf("reset_res%0d", k), 8'(res_of(k)), 8'(R_0));
      chk($sformatf("reset_le%0d", k), 8'(le[k]), 8'd0);
    end
    @(posedge clk);
    #1;

    // Unsigned MSB-first 3-digit frame (short for FD=4).
    add(0, 0, 1, 1, 0, 4'h3, 4'h3, 1, R_EQ, 0, R_0, 0);
    add(0, 0, 1, 0, 0, 4'hA, 4'hA, 1, R_EQ, 0, R_0, 0);
    add(0, 0, 1, 0, 1, 4'h7, 4'h5, 1, R_GT, 0, R_0, 0);
    add(0, 0, 0, 0, 0, 4'h0, 4'h0, 1, R_EQ, 1, R_GT, LE_ON);
    add(0, 0, 0, 0, 0, 4'h0, 4'h0, 1, R_EQ, 0, R_GT, 0);
    // Full-length frame, sticky after first difference is exercised by random part.
    add(0, 0, 1, 1, 0, 4'h1, 4'h1, 1, R_EQ, 0, R_GT, 0);
    add(0, 0, 1, 0, 0, 4'h2, 4'h2, 1, R_EQ, 0, R_GT, 0);
    add(0, 0, 1, 0, 0, 4'h3, 4'h3, 1, R_EQ, 0, R_GT, 0);
    add(0, 0, 1, 0, 1, 4'h3, 4'h4, 1, R_LT, 0, R_GT, 0);
    add(0, 0, 0, 0, 0, 4'h0, 4'h0, 1, R_EQ, 1, R_LT, 0);
    // Signed MSB-first: 0xF0 vs 0x10.
    add_rst();
    add(2, 0, 1, 1, 0, 4'hF, 4'h1, 1, R_LT, 0, R_0, 0);
    add(2, 0, 1, 0, 1, 4'h0, 4'h0, 1, R_LT, 0, R_0, 0);
    add(2, 0, 0, 0, 0, 4'h0, 4'h0, 1, R_EQ, 1, R_LT, LE_ON);
    // Same stimulus, unsigned instance.
    add_rst();
    add(0, 0, 1, 1, 0, 4'hF, 4'h1, 1, R_GT, 0, R_0, 0);
    add(0, 0, 1, 0, 1, 4'h0, 4'h0, 1, R_GT, 0, R_0, 0);
    add(0, 0, 0, 0, 0, 4'h0, 4'h0, 1, R_EQ, 1, R_GT, LE_ON);
    // Signed LSB-first with a gap carrying junk delimiters.
    add_rst();
    add(3, 0, 1, 1, 0, 4'h0, 4'h0, 1, R_EQ, 0, R_0, 0);
    add(3, 0, 0, 1, 1, 4'h5, 4'h9, 1, R_EQ, 0, R_0, 0);
    add(3, 0, 1, 0, 1, 4'hF, 4'h1, 1, R_LT, 0, R_0, 0);
    add(3, 0, 0, 0, 0, 4'h0, 4'h0, 1, R_EQ, 1, R_LT, LE_ON);
    // Restart by a second 'first', then single-digit frame.
    add_rst();
    add(0, 0, 1, 1, 0, 4'h5, 4'h5, 1, R_EQ, 0, R_0, 0);
    add(0, 0, 1, 1, 1, 4'h1, 4'h2, 1, R_LT, 0, R_0, 0);
    add(0, 0, 0, 0, 0, 4'h0, 4'h0, 1, R_EQ, 1, R_LT, LE_ON);
    // Reset mid-frame coinciding with 'last': result must be discarded.
    add(0, 0, 1, 1, 0, 4'h9, 4'h2, 1, R_GT, 0, R_LT, 0);
    add(0, 1, 1, 0, 1, 4'h1, 4'h2, 0, R_0, 0, R_0, 0);
    add(0, 0, 0, 0, 0, 4'h0, 4'h0, 1, R_EQ, 0, R_0, 0);
    // Digit without a preceding 'first' after reset.
    add(0, 0, 1, 0, 1, 4'h2, 4'h1, 1, R_GT, 0, R_0, 0);
    add(0, 0, 0, 0, 0, 4'h0, 4'h0, 1, R_EQ, 1, R_GT, LE_ON);

    for (int i = 0; i < ntbl; i++) begin
      rst = tbl[i].r; valid = tbl[i].v; first = tbl[i].f; last = tbl[i].l;
      a = tbl[i].a; b = tbl[i].b;
      @(negedge clk);
      if (tbl[i].ck) begin
        chk($sformatf("vec%0d_run", i), 8'(run_of(tbl[i].inst)), 8'(tbl[i].run));
        chk($sformatf("vec%0d_rv", i), 8'(rv[tbl[i].inst]), 8'(tbl[i].rv));
        chk($sformatf("vec%0d_res", i), 8'(res_of(tbl[i].inst)), 8'(tbl[i].res));
        chk($sformatf("vec%0d_le", i), 8'(le[tbl[i].inst]), 8'(tbl[i].le));
      end
      @(posedge clk);
      #1;
    end
    rst = 1'b0;

    // 1-bit LSB-first 16-digit frame, digit 0 leftmost in the strings.
    ta  = 16'b0110_0100_1000_0010;
    tb2 = 16'b0110_0010_0110_0010;
    el  = 16'b0000_0011_0111_1111;
    ee  = 16'b1111_1000_0000_0000;
    for (int i = 0; i < 16; i++) begin
      valid = 1'b1; first = (i == 0); last = (i == 15);
      a = {3'b000, ta[15-i]}; b = {3'b000, tb2[15-i]};
      @(negedge clk);
      chk($sformatf("lsb16_less%0d", i), 8'(lt[1]), 8'(el[15-i]));
      chk($sformatf("lsb16_eq%0d", i), 8'(eq[1]), 8'(ee[15-i]));
      @(posedge clk);
      #1;
    end
    valid = 1'b0; first = 1'b0; last = 1'b0;
    @(negedge clk);
    chk("lsb16_rv", 8'(rv[1]), 8'd1);
    chk("lsb16_res", 8'(res_of(1)), 8'(R_LT));
    @(posedge clk);
    #1;

    // Randomised frames against the model.
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    m_n = 0; m_rv = 0; m_le = 0;
    for (int k = 0; k < 4; k++) m_res[k] = R_0;
    for (int fr = 0; fr < 60; fr++) begin
      len = $urandom_range(1, 8);
      for (int i = 0; i < len; i++) begin
        if ($urandom_range(0, 3) == 0)
          rcycle(0, 1'($urandom), 1'($urandom), 4'($urandom), 4'($urandom));
        f  = (i == 0) || ($urandom_range(0, 11) == 0);
        l  = (i == len - 1);
        av = 4'($urandom);
        bv = ($urandom_range(0, 2) == 0) ? 4'($urandom) : av;
        rcycle(1, f, l, av, bv);
      end
      if ($urandom_range(0, 2) == 0) rcycle(0, 0, 0, 4'h0, 4'h0);
    end
    rcycle(0, 0, 0, 4'h0, 4'h0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
